// File: rtl/debug_loader.sv
// Framed byte-stream loader driving the core's debug instruction-write port.
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module debug_loader #(
   parameter int unsigned MAX_WORDS = 1024,
   parameter int unsigned ADDR_STEP = 4
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   input  logic        abort,
   output logic        DEBUG_SIG,
   output logic [31:0] DEBUG_addr,
   output logic [31:0] DEBUG_instr,
   output logic        DEBUG_we,
   output logic        load_done,
   output logic        load_err,
   output logic [15:0] words_loaded
);

   typedef enum logic [2:0] {
      StIdle, StAddr, StCnt, StData, StWrite, StCsum, StDone
   } state_t;

`ifdef LOADER_CHECKSUM_EN
   localparam state_t StAfterData = StCsum;
`else
   localparam state_t StAfterData = StDone;
`endif

   state_t      r_state;
   state_t      w_state_nxt;
   logic [1:0]  r_bcnt;
   logic [23:0] r_shift;
   logic [7:0]  r_cnt_lo;
   logic [15:0] r_cnt;
   logic [31:0] r_waddr;
   logic        r_rx_ready;
   logic        r_sig;
   logic        r_we;
   logic        r_done;
   logic        r_err;
   logic [31:0] r_addr;
   logic [31:0] r_instr;
   logic [15:0] r_words;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]  r_csum;
`endif

   logic        w_fire;
   logic [31:0] w_shift;
   logic [15:0] w_cnt;

   assign w_fire  = rx_valid & r_rx_ready;
   // Bytes arrive LSB first, so each new byte enters at the top of the word.
   assign w_shift = {rx_data, r_shift};
   assign w_cnt   = {rx_data, r_cnt_lo};

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle:  if (w_fire && rx_data == 8'hA5) w_state_nxt = StAddr;
         StAddr:  if (w_fire && r_bcnt == 2'd3)
                     w_state_nxt = (w_shift[1:0] != 2'b00) ? StIdle : StCnt;
         StCnt:   if (w_fire && r_bcnt == 2'd1) begin
                     if (32'(w_cnt) > MAX_WORDS) w_state_nxt = StIdle;
                     else if (w_cnt == 16'd0)    w_state_nxt = StAfterData;
                     else                        w_state_nxt = StData;
                  end
         StData:  if (w_fire && r_bcnt == 2'd3) w_state_nxt = StWrite;
         StWrite: w_state_nxt = (r_words == r_cnt) ? StAfterData : StData;
`ifdef LOADER_CHECKSUM_EN
         StCsum:  if (w_fire) w_state_nxt = (rx_data == r_csum) ? StDone : StIdle;
`else
         StCsum:  w_state_nxt = StIdle;
`endif
         StDone:  w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
      if (abort) w_state_nxt = StIdle;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state    <= StIdle;
         r_bcnt     <= 2'd0;
         r_shift    <= 24'd0;
         r_cnt_lo   <= 8'd0;
         r_cnt      <= 16'd0;
         r_waddr    <= 32'd0;
         r_rx_ready <= 1'b1;
         r_sig      <= 1'b0;
         r_we       <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_addr     <= 32'd0;
         r_instr    <= 32'd0;
         r_words    <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
         r_csum     <= 8'd0;
`endif
      end else begin
         r_state    <= w_state_nxt;
         r_rx_ready <= (w_state_nxt != StWrite) && (w_state_nxt != StDone);
         r_sig      <= (w_state_nxt != StIdle) && (w_state_nxt != StDone);
         r_we       <= (w_state_nxt == StWrite);
         r_done     <= (w_state_nxt == StDone);
         if (!abort && w_fire) begin
            case (r_state)
               StIdle: if (rx_data == 8'hA5) begin
                  r_err   <= 1'b0;
                  r_words <= 16'd0;
                  r_bcnt  <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
                  r_csum  <= 8'd0;
`endif
               end
               StAddr: begin
                  r_shift <= w_shift[31:8];
                  r_bcnt  <= r_bcnt + 2'd1;
                  if (r_bcnt == 2'd3) begin
                     r_waddr <= w_shift;
                     if (w_shift[1:0] != 2'b00) r_err <= 1'b1;
                  end
               end
               StCnt: begin
                  r_cnt_lo <= rx_data;
                  if (r_bcnt == 2'd1) begin
                     r_bcnt <= 2'd0;
                     r_cnt  <= w_cnt;
                     if (32'(w_cnt) > MAX_WORDS) r_err <= 1'b1;
                  end else begin
                     r_bcnt <= r_bcnt + 2'd1;
                  end
               end
               StData: begin
                  r_shift <= w_shift[31:8];
                  r_bcnt  <= r_bcnt + 2'd1;
                  if (r_bcnt == 2'd3) begin
                     r_addr  <= r_waddr;
                     r_instr <= w_shift;
                     r_waddr <= r_waddr + ADDR_STEP;
                     r_words <= r_words + 16'd1;
                  end
               end
`ifdef LOADER_CHECKSUM_EN
               StCsum: if (rx_data != r_csum) r_err <= 1'b1;
`endif
               default: ;
            endcase
`ifdef LOADER_CHECKSUM_EN
            if (r_state == StAddr || r_state == StCnt || r_state == StData)
               r_csum <= r_csum ^ rx_data;
`endif
         end
      end
   end

   assign rx_ready     = r_rx_ready;
   assign DEBUG_SIG    = r_sig;
   assign DEBUG_addr   = r_addr;
   assign DEBUG_instr  = r_instr;
   assign DEBUG_we     = r_we;
   assign load_done    = r_done;
   assign load_err     = r_err;
   assign words_loaded = r_words;

endmodule

// File: tb/tb_debug_loader.sv
// Scoreboard bench for debug_loader: expected writes are queued as frames are driven and
// popped as DEBUG_we pulses appear. Works with or without LOADER_CHECKSUM_EN.
module tb_debug_loader;

   localparam int unsigned MaxWords = 1024;
   localparam int unsigned AddrStep = 4;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_ready;
   logic        abort = 1'b0;
   logic        DEBUG_SIG;
   logic [31:0] DEBUG_addr;
   logic [31:0] DEBUG_instr;
   logic        DEBUG_we;
   logic        load_done;
   logic        load_err;
   logic [15:0] words_loaded;

   int          n_checks = 0;
   int          n_pass = 0;
   int          n_done = 0;
   int          exp_done = 0;
   bit          stall = 1'b0;
   logic [7:0]  tx_csum;
   logic [63:0] exp_q[$];
   logic [31:0] wq[$];

   debug_loader #(
      .MAX_WORDS(MaxWords),
      .ADDR_STEP(AddrStep)
   ) dut (
      .clk         (clk),
      .nrst        (nrst),
      .rx_valid    (rx_valid),
      .rx_data     (rx_data),
      .rx_ready    (rx_ready),
      .abort       (abort),
      .DEBUG_SIG   (DEBUG_SIG),
      .DEBUG_addr  (DEBUG_addr),
      .DEBUG_instr (DEBUG_instr),
      .DEBUG_we    (DEBUG_we),
      .load_done   (load_done),
      .load_err    (load_err),
      .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   always @(negedge clk) begin : monitor
      logic [63:0] e;
      if (DEBUG_we) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", DEBUG_addr, 32'hxxxxxxxx);
         end else begin
            e = exp_q.pop_front();
            check("write_addr", DEBUG_addr, e[63:32]);
            check("write_instr", DEBUG_instr, e[31:0]);
         end
      end
      if (load_done) begin
         n_done++;
         check("sig_low_at_done", 32'(DEBUG_SIG), 32'd0);
      end
   end

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Returns #1 after the edge that consumed the byte.
   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      if (stall) begin
         rx_valid = 1'b0;
         cycles(1);
      end
      rx_valid = 1'b1;
      rx_data  = b;
      while (!rx_ready && n < 100) begin
         cycles(1);
         n++;
      end
      if (n >= 100) check("ready_timeout", 32'(rx_ready), 32'd1);
      cycles(1);
      rx_valid = 1'b0;
   endtask

   task automatic send_cs(input logic [7:0] b);
      tx_csum = tx_csum ^ b;
      send_byte(b);
   endtask

   task automatic send_frame(input logic [31:0] base, input bit bad_csum);
      logic [15:0] cnt;
      logic [31:0] w;
      cnt = 16'(wq.size());
      tx_csum = 8'h00;
      send_byte(8'hA5);
      for (int i = 0; i < 4; i++) send_cs(base[8*i +: 8]);
      for (int i = 0; i < 2; i++) send_cs(cnt[8*i +: 8]);
      for (int k = 0; k < int'(cnt); k++) begin
         w = wq[k];
         exp_q.push_back({base + 32'(k) * AddrStep, w});
         for (int i = 0; i < 4; i++) send_cs(w[8*i +: 8]);
         check("we_after_4th_byte", 32'(DEBUG_we), 32'd1);
         check("ready_low_in_write", 32'(rx_ready), 32'd0);
      end
`ifdef LOADER_CHECKSUM_EN
      send_byte(bad_csum ? ~tx_csum : tx_csum);
      if (!bad_csum) exp_done++;
`else
      if (!bad_csum) exp_done++;
`endif
      cycles(4);
      check("words_loaded", 32'(words_loaded), 32'(cnt));
      check("done_count", 32'(n_done), 32'(exp_done));
      check("sig_idle", 32'(DEBUG_SIG), 32'd0);
      wq.delete();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      cycles(3);
      nrst = 1'b1;
      cycles(1);
      check("rst_rx_ready", 32'(rx_ready), 32'd1);
      check("rst_sig", 32'(DEBUG_SIG), 32'd0);
      check("rst_addr", DEBUG_addr, 32'd0);
      check("rst_instr", DEBUG_instr, 32'd0);
      check("rst_we", 32'(DEBUG_we), 32'd0);
      check("rst_done", 32'(load_done), 32'd0);
      check("rst_err", 32'(load_err), 32'd0);
      check("rst_words", 32'(words_loaded), 32'd0);

      // Normal frame
      wq.push_back(32'h00000013);
      wq.push_back(32'h00100093);
      send_frame(32'h00000100, 1'b0);
      check("normal_err", 32'(load_err), 32'd0);

      // Garbage then sync, with an address that wraps
      send_byte(8'hFF);
      send_byte(8'h00);
      check("garbage_sig", 32'(DEBUG_SIG), 32'd0);
      check("garbage_ready", 32'(rx_ready), 32'd1);
      wq.push_back(32'hCAFEF00D);
      wq.push_back(32'h0BADBEEF);
      send_frame(32'hFFFFFFFC, 1'b0);

      // Misaligned address
      send_byte(8'hA5);
      check("sig_after_sync", 32'(DEBUG_SIG), 32'd1);
      send_byte(8'h02);
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h00);
      cycles(2);
      check("misalign_err", 32'(load_err), 32'd1);
      check("misalign_sig", 32'(DEBUG_SIG), 32'd0);

      // Sync clears the error; count 0 finishes with no writes
      send_frame(32'h00000200, 1'b0);
      check("zero_cnt_err_cleared", 32'(load_err), 32'd0);

      // Count above MAX_WORDS
      send_byte(8'hA5);
      for (int i = 0; i < 4; i++) send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'h04);
      cycles(2);
      check("cnt_over_err", 32'(load_err), 32'd1);
      check("cnt_over_sig", 32'(DEBUG_SIG), 32'd0);
      check("cnt_over_ready", 32'(rx_ready), 32'd1);

      // Stalled stream gives identical writes
      stall = 1'b1;
      wq.push_back(32'hDEADBEEF);
      wq.push_back(32'h12345678);
      send_frame(32'h00000040, 1'b0);
      stall = 1'b0;

      // Abort after two data bytes
      send_byte(8'hA5);
      send_byte(8'h00);
      send_byte(8'h03);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'h00);
      send_byte(8'h11);
      send_byte(8'h22);
      abort = 1'b1;
      cycles(1);
      abort = 1'b0;
      check("abort_sig", 32'(DEBUG_SIG), 32'd0);
      check("abort_ready", 32'(rx_ready), 32'd1);
      check("abort_err", 32'(load_err), 32'd0);
      send_byte(8'h33);
      send_byte(8'h44);
      cycles(3);
      check("abort_no_reentry", 32'(DEBUG_SIG), 32'd0);

      wq.push_back(32'hA5A5A5A5);
      send_frame(32'h00000800, 1'b0);

`ifdef LOADER_CHECKSUM_EN
      // Corrupted checksum: writes land, error set, no done
      wq.push_back(32'h00000013);
      send_frame(32'h00000900, 1'b1);
      check("csum_err", 32'(load_err), 32'd1);
`endif

      cycles(2);
      check("writes_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
